lfsr_arbiter: RTL and testbench

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

---
 rtl/lfsr_arbiter.sv | 82 ++++++++
 tb/tb_lfsr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// Two-requester round-robin arbiter that hands the winner a burst of words
// from a 6-bit maximal-length LFSR, one word per cycle.
module lfsr_arbiter #(
  parameter logic [5:0] SEED = 6'b000001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [5:0] len0,
  input  logic [5:0] len1,
  output logic [1:0] gnt,
  output logic       rnd_valid,
  output logic [5:0] rnd_data,
  output logic       rnd_id,
  output logic [1:0] done,
  output logic       busy
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [5:0] SEED_EFF = (SEED == 6'd0) ? 6'd1 : SEED;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic       state;
  logic [5:0] lfsr;
  logic       ptr;
  logic       owner;
  logic [6:0] remaining;

  logic       winner;
  logic [5:0] win_len;
  logic       last;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner = ptr;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
    win_len = winner ? len1 : len0;
  end

  assign last = (remaining == 7'd1);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= SEED_EFF;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      remaining <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            state <= ST_BURST;
            owner <= winner;
            ptr   <= ~winner;
            // A length of zero means a full 64-word burst.
            remaining <= (win_len == 6'd0) ? 7'd64 : {1'b0, win_len};
          end
        end
        ST_BURST: begin
          lfsr      <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
          remaining <= remaining - 7'd1;
          if (last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_BURST);
  assign rnd_valid = busy;
  assign gnt       = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done      = (busy && last) ? gnt : 2'b00;
  assign rnd_data  = lfsr;
  assign rnd_id    = owner;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: queue-based burst model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_lfsr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [5:0] len0, len1;
  logic [1:0] gnt;
  logic       rnd_valid;
  logic [5:0] rnd_data;
  logic       rnd_id;
  logic [1:0] done;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_id(rnd_id), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the LFSR as a precomputed 63-entry sequence indexed by
  // the number of words emitted so far, and each granted burst as a queue of
  // owner ids, one entry per word still to be delivered.
  logic [5:0] seq [63];
  bit         words [$];
  int         idx;
  bit         ptr_m;
  bit         id_m;

  initial begin : model
    logic [5:0] s;
    logic [1:0] e_gnt;
    bit         w;
    int         n;
    s = 6'd1;
    for (int i = 0; i < 63; i++) begin
      seq[i] = s;
      s = {s[4:0], s[5] ^ s[4]};
    end
    idx = 0; ptr_m = 0; id_m = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        words.delete();
        idx = 0; ptr_m = 0; id_m = 0;
      end
      e_gnt = (words.size() != 0) ? (words[0] ? 2'b10 : 2'b01) : 2'b00;
      check("gnt", gnt, e_gnt);
      check("busy", busy, words.size() != 0);
      check("rnd_valid", rnd_valid, words.size() != 0);
      check("done", done, (words.size() == 1) ? e_gnt : 2'b00);
      check("rnd_data", rnd_data, seq[idx % 63]);
      check("rnd_id", rnd_id, (words.size() != 0) ? words[0] : id_m);
      if (!rst) begin
        if (words.size() != 0) begin
          void'(words.pop_front());
          idx++;
        end else if (req != 2'b00) begin
          w = (req == 2'b11) ? ptr_m : req[1];
          n = w ? int'(len1) : int'(len0);
          if (n == 0) n = 64;
          repeat (n) words.push_back(w);
          ptr_m = !w;
          id_m  = w;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy;
    int k = 0;
    while (!busy && k < 200) begin
      step();
      k++;
    end
    check("wait_busy", busy, 1'b1);
  endtask

  initial begin : stim
    int         nwords, ndones;
    logic [5:0] w63, w64;
    rst = 1'b1; req = 2'b00; len0 = 6'd0; len1 = 6'd0;
    repeat (3) step();

    // Model pins: sequence start, a later word, and the word before the wrap.
    check("seq0", seq[0], 6'b000001);
    check("seq5", seq[5], 6'b100001);
    check("seq62", seq[62], 6'b100000);
    check("reset_data", rnd_data, 6'b000001);
    check("reset_gnt", gnt, 2'b00);

    // Single requester, 3-word burst, then a second burst continuing the LFSR.
    rst = 1'b0; req = 2'b01; len0 = 6'd3;
    step();
    check("b1_w1_gnt", gnt, 2'b01);
    check("b1_w1_data", rnd_data, 6'b000001);
    step();
    check("b1_w2_data", rnd_data, 6'b000010);
    check("b1_w2_done", done, 2'b00);
    step();
    check("b1_w3_data", rnd_data, 6'b000100);
    check("b1_w3_done", done, 2'b01);
    step();
    check("b1_idle_gnt", gnt, 2'b00);
    step();
    check("b2_w1_data", rnd_data, 6'b001000);
    req = 2'b00;
    repeat (5) step();

    // Reset in the middle of a 10-word burst, then both request together.
    req = 2'b01; len0 = 6'd10;
    wait_busy();
    repeat (4) step();
    #1 rst = 1'b1;
    #1;
    check("arst_gnt", gnt, 2'b00);
    check("arst_busy", busy, 1'b0);
    check("arst_valid", rnd_valid, 1'b0);
    check("arst_data", rnd_data, 6'b000001);
    step();
    req = 2'b11; len0 = 6'd2; len1 = 6'd2;
    step();
    rst = 1'b0;
    step();
    check("rr_w1_id", rnd_id, 1'b0);
    check("rr_w1_data", rnd_data, 6'b000001);
    step();
    check("rr_w2_done", done, 2'b01);
    step();
    check("rr_idle_busy", busy, 1'b0);
    step();
    check("rr_w3_id", rnd_id, 1'b1);
    check("rr_w3_data", rnd_data, 6'b000100);
    step();
    check("rr_w4_data", rnd_data, 6'b001000);
    check("rr_w4_done", done, 2'b10);
    req = 2'b00;
    repeat (6) step();

    // Length 0 yields 64 words with the period wrap; req/len changes ignored.
    rst = 1'b1;
    step();
    rst = 1'b0; req = 2'b01; len0 = 6'd0;
    step();
    check("l0_w1_data", rnd_data, 6'b000001);
    req = 2'b00; len0 = 6'd5;
    nwords = 1; ndones = (done != 2'b00) ? 1 : 0;
    w63 = '0; w64 = '0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (busy) begin
        nwords++;
        if (nwords == 63) w63 = rnd_data;
        if (nwords == 64) w64 = rnd_data;
        if (done != 2'b00) ndones++;
      end
    end
    check("l0_count", nwords, 64);
    check("l0_word63", w63, 6'b100000);
    check("l0_word64", w64, 6'b000001);
    check("l0_dones", ndones, 1);

    // Random traffic with occasional resets, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      len0 = 6'($urandom_range(0, 9));
      len1 = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 5));
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
